// File: rtl/trng_crngt.sv
// Continuous repeated-sample test: each collector sample is compared with the previous one.
// Define CRNGT_ERR_CNT_EN to build the saturating failure counter behind crngt_err_cnt.
module trng_crngt #(
    parameter int DATA_W = 16
) (
    input  logic              rng_clk,
    input  logic              rst_n,
    input  logic              rst_trng_logic,
    input  logic              collector_valid,
    input  logic [DATA_W-1:0] collector_data,
    input  logic              trng_crngt_bypass,
    input  logic              accum_enough_bits,
    input  logic              err_clr,
    output logic              crngt_valid,
    output logic [DATA_W-1:0] crngt_data,
    output logic              curr_test_err,
    output logic              crngt_err,
    output logic [7:0]        crngt_err_cnt
);

    typedef enum logic {
        PRIME = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_ref_q;
    logic [DATA_W-1:0] r_data_p0;
    logic              r_valid_p0;
    logic              r_test_err_p0;
    logic              r_err;

    // A soft reset or bypass swallows the sample before it reaches the test.
    logic w_sample;
    logic w_match;
    logic w_fail;

    assign w_sample = collector_valid && !trng_crngt_bypass && !rst_trng_logic;
    assign w_match  = (collector_data == r_ref_q);
    assign w_fail   = w_sample && (r_state == ARMED) && w_match;

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= PRIME;
            r_ref_q       <= '0;
            r_data_p0     <= '0;
            r_valid_p0    <= 1'b0;
            r_test_err_p0 <= 1'b0;
            r_err         <= 1'b0;
        end else if (rst_trng_logic) begin
            r_state       <= PRIME;
            r_ref_q       <= '0;
            r_data_p0     <= '0;
            r_valid_p0    <= 1'b0;
            r_test_err_p0 <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_valid_p0    <= 1'b0;
            r_test_err_p0 <= 1'b0;
            if (err_clr) begin
                r_err <= 1'b0;
            end
            if (trng_crngt_bypass) begin
                r_state <= PRIME;
            end else if (w_sample) begin
                case (r_state)
                    PRIME: begin
                        r_ref_q <= collector_data;
                        r_state <= ARMED;
                    end
                    ARMED: begin
                        if (w_match) begin
                            // Failure drops the reference; the next sample re-primes.
                            r_test_err_p0 <= 1'b1;
                            r_err         <= 1'b1;
                            r_state       <= PRIME;
                        end else begin
                            r_ref_q <= collector_data;
                            if (!accum_enough_bits) begin
                                r_valid_p0 <= 1'b1;
                                r_data_p0  <= collector_data;
                            end
                        end
                    end
                    default: r_state <= PRIME;
                endcase
            end
        end
    end

    assign crngt_valid   = r_valid_p0;
    assign crngt_data    = r_data_p0;
    assign curr_test_err = r_test_err_p0;
    assign crngt_err     = r_err;

`ifdef CRNGT_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Counts on the same edge that raises curr_test_err; survives the soft reset.
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_fail) begin
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end
    end

    assign crngt_err_cnt = r_err_cnt;
`else
    logic w_unused_fail;

    assign w_unused_fail = w_fail;
    assign crngt_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_trng_crngt.sv
// Bench for trng_crngt: directed scenarios followed by random traffic, checked against
// a sample-level model of the repeated-sample test.
module tb_trng_crngt;

    logic        rng_clk;
    logic        rst_n;
    logic        rst_trng_logic;
    logic        collector_valid;
    logic [15:0] collector_data;
    logic        trng_crngt_bypass;
    logic        accum_enough_bits;
    logic        err_clr;
    logic        crngt_valid;
    logic [15:0] crngt_data;
    logic        curr_test_err;
    logic        crngt_err;
    logic [7:0]  crngt_err_cnt;

    int errors = 0;
    int checks = 0;

    // Model: the last accepted sample (if any), sticky error, last output word, count.
    bit          m_have_ref;
    logic [15:0] m_ref;
    logic [15:0] m_data;
    bit          m_err;
    int          m_cnt;
    bit          m_cnt_en;

    trng_crngt dut (
        .rng_clk           (rng_clk),
        .rst_n             (rst_n),
        .rst_trng_logic    (rst_trng_logic),
        .collector_valid   (collector_valid),
        .collector_data    (collector_data),
        .trng_crngt_bypass (trng_crngt_bypass),
        .accum_enough_bits (accum_enough_bits),
        .err_clr           (err_clr),
        .crngt_valid       (crngt_valid),
        .crngt_data        (crngt_data),
        .curr_test_err     (curr_test_err),
        .crngt_err         (crngt_err),
        .crngt_err_cnt     (crngt_err_cnt)
    );

    initial rng_clk = 1'b0;
    always #5 rng_clk = ~rng_clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the spec rules, compare all outputs.
    task automatic step(input string tag, input bit cv, input logic [15:0] s, input bit accum,
                        input bit byp, input bit clr, input bit rstl);
        bit ev;
        bit et;
        @(negedge rng_clk);
        collector_valid   = cv;
        collector_data    = s;
        accum_enough_bits = accum;
        trng_crngt_bypass = byp;
        err_clr           = clr;
        rst_trng_logic    = rstl;
        @(negedge rng_clk);
        collector_valid = 1'b0;
        err_clr         = 1'b0;
        rst_trng_logic  = 1'b0;
        ev = 0;
        et = 0;
        if (rstl) begin
            m_have_ref = 0;
            m_ref      = 16'h0;
            m_data     = 16'h0;
            m_err      = 0;
        end else begin
            if (clr) m_err = 0;
            if (byp) begin
                m_have_ref = 0;
            end else if (cv) begin
                if (!m_have_ref) begin
                    m_have_ref = 1;
                    m_ref      = s;
                end else if (s == m_ref) begin
                    et         = 1;
                    m_have_ref = 0;
                    m_err      = 1;
                end else begin
                    m_ref = s;
                    if (!accum) begin
                        ev     = 1;
                        m_data = s;
                    end
                end
            end
        end
        if (m_cnt_en) begin
            if (et) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            else if (clr) m_cnt = 0;
        end
        check({tag, ".valid"}, {15'd0, crngt_valid}, {15'd0, ev});
        check({tag, ".test_err"}, {15'd0, curr_test_err}, {15'd0, et});
        check({tag, ".data"}, crngt_data, m_data);
        check({tag, ".err"}, {15'd0, crngt_err}, {15'd0, m_err});
        check({tag, ".cnt"}, {8'd0, crngt_err_cnt}, m_cnt[15:0]);
    endtask

    initial begin
        logic [15:0] r;
`ifdef CRNGT_ERR_CNT_EN
        m_cnt_en = 1;
`else
        m_cnt_en = 0;
`endif
        m_have_ref = 0; m_ref = 0; m_data = 0; m_err = 0; m_cnt = 0;
        rst_n = 1'b0;
        rst_trng_logic = 0; collector_valid = 0; collector_data = 0;
        trng_crngt_bypass = 0; accum_enough_bits = 0; err_clr = 0;
        repeat (3) @(negedge rng_clk);
        check("rst.valid", {15'd0, crngt_valid}, 16'h0);
        check("rst.test_err", {15'd0, curr_test_err}, 16'h0);
        check("rst.data", crngt_data, 16'h0);
        check("rst.err", {15'd0, crngt_err}, 16'h0);
        check("rst.cnt", {8'd0, crngt_err_cnt}, 16'h0);
        rst_n = 1'b1;

        // First sample only primes; the second one is forwarded.
        step("prime1234", 1, 16'h1234, 0, 0, 0, 0);
        step("pass5678", 1, 16'h5678, 0, 0, 0, 0);
        check("pass5678.exact", crngt_data, 16'h5678);

        // Repeat detection, sticky error, re-prime after failure.
        step("aaaa", 1, 16'hAAAA, 0, 0, 0, 0);
        step("bbbb", 1, 16'hBBBB, 0, 0, 0, 0);
        step("bbbb_fail", 1, 16'hBBBB, 0, 0, 0, 0);
        check("bbbb_fail.exact", {15'd0, curr_test_err}, 16'h1);
        step("bbbb_reprime", 1, 16'hBBBB, 0, 0, 0, 0);
        check("bbbb_reprime.sticky", {15'd0, crngt_err}, 16'h1);
        step("clr", 0, 16'h0, 0, 0, 1, 0);
        // Set wins over a coincident clear.
        step("set_vs_clr", 1, 16'hBBBB, 0, 0, 1, 0);
        check("set_vs_clr.exact", {15'd0, crngt_err}, 16'h1);

        // EHR full: passing samples dropped, reference still tracked.
        step("soft_rst", 0, 16'h0, 0, 0, 0, 1);
        step("full_0001", 1, 16'h0001, 1, 0, 0, 0);
        step("full_0002", 1, 16'h0002, 1, 0, 0, 0);
        step("full_0002_fail", 1, 16'h0002, 1, 0, 0, 0);

        // Bypass ignores repeats; leaving bypass re-primes.
        step("clr2", 0, 16'h0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("bypass5555", 1, 16'h5555, 0, 1, 0, 0);
        step("unbyp_prime", 1, 16'h5555, 0, 0, 0, 0);
        step("unbyp_fail", 1, 16'h5555, 0, 0, 0, 0);

        // Soft reset beats a coincident sample while armed.
        step("arm1111", 1, 16'h1111, 0, 0, 0, 0);
        step("rst_vs_9999", 1, 16'h9999, 0, 0, 0, 1);
        step("after_rst_9999", 1, 16'h9999, 0, 0, 0, 0);
        step("after_rst_9998", 1, 16'h9998, 0, 0, 0, 0);

        // Random traffic from a small alphabet so repeats are frequent.
        for (int i = 0; i < 300; i++) begin
            r = 16'($urandom_range(0, 3)) ^ 16'h3C00;
            step("rand", $urandom_range(0, 5) != 0, r, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 19) == 0);
        end

`ifdef CRNGT_ERR_CNT_EN
        step("cnt_clr", 0, 16'h0, 0, 0, 1, 0);
        for (int i = 0; i < 300; i++) begin
            step("force_prime", 1, 16'hC0DE, 0, 0, 0, 0);
            step("force_fail", 1, 16'hC0DE, 0, 0, 0, 0);
        end
        check("cnt_sat", {8'd0, crngt_err_cnt}, 16'h00FF);
        step("cnt_clr2", 0, 16'h0, 0, 0, 1, 0);
        check("cnt_cleared", {8'd0, crngt_err_cnt}, 16'h0000);
`else
        for (int i = 0; i < 4; i++) begin
            step("nocnt_prime", 1, 16'hC0DE, 0, 0, 0, 0);
            step("nocnt_fail", 1, 16'hC0DE, 0, 0, 0, 0);
        end
        check("cnt_tied", {8'd0, crngt_err_cnt}, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trng_crngt.md
TRNG_CRNGT -- requirements
Module: trng_crngt

Interface
REQ-001 SHALL have port rng_clk, input, 1 bit: TRNG domain clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port rst_trng_logic, input, 1 bit: synchronous soft reset of TRNG datapath.
REQ-004 SHALL have port collector_valid, input, 1 bit: one-cycle strobe, collector_data holds a new sample.
REQ-005 SHALL have port collector_data, input, 16 bits: raw sample from the bit collector.
REQ-006 SHALL have port trng_crngt_bypass, input, 1 bit: 1 = continuous test disabled.
REQ-007 SHALL have port accum_enough_bits, input, 1 bit: downstream EHR is full.
REQ-008 SHALL have port err_clr, input, 1 bit: CPU write-one-clear of the sticky error.
REQ-009 SHALL have port crngt_valid, output, 1 bit: one-cycle strobe, crngt_data holds a tested sample.
REQ-010 SHALL have port crngt_data, output, 16 bits: tested sample.
REQ-011 SHALL have port curr_test_err, output, 1 bit: one-cycle strobe on repeated-sample failure.
REQ-012 SHALL have port crngt_err, output, 1 bit: sticky failure flag.
REQ-013 SHALL have port crngt_err_cnt, output, 8 bits: failure count (see Configuration).

Function
REQ-014 SHALL implement FSM states PRIME (no reference held) and ARMED (reference register ref_q valid).
REQ-015 In PRIME, a collector_valid sample SHALL load ref_q, SHALL produce no crngt_valid, and SHALL move the FSM to ARMED.
REQ-016 In ARMED, a sample equal to ref_q SHALL pulse curr_test_err the next cycle, set crngt_err, suppress crngt_valid, and return the FSM to PRIME.
REQ-017 In ARMED, a sample differing from ref_q SHALL load ref_q with the sample and, if accum_enough_bits=0, pulse crngt_valid with crngt_data = sample the next cycle.
REQ-018 A differing sample arriving while accum_enough_bits=1 SHALL update ref_q and SHALL be dropped, with no crngt_valid.
REQ-019 Latency: crngt_valid, crngt_data and curr_test_err SHALL be registered, one cycle after collector_valid.
REQ-020 crngt_valid and curr_test_err SHALL never be high in the same cycle.
REQ-021 crngt_data SHALL hold its last value when crngt_valid=0.
REQ-022 When trng_crngt_bypass=1, the block SHALL hold PRIME, assert neither strobe, and ignore samples; downstream accounts for bypassed samples.
REQ-023 A 1->0 transition of trng_crngt_bypass SHALL leave the FSM in PRIME, so the first sample re-primes.
REQ-024 crngt_err SHALL clear on err_clr or rst_trng_logic; a same-cycle set SHALL win over err_clr.
REQ-025 rst_trng_logic SHALL take priority over a coincident collector_valid: FSM to PRIME, strobes low, sample discarded.

Reset
REQ-026 On rst_n=0 the FSM SHALL be PRIME, ref_q=0, crngt_data=0, and crngt_valid, curr_test_err, crngt_err and crngt_err_cnt SHALL be 0.
REQ-027 rst_trng_logic SHALL produce the same state as REQ-026, except crngt_err_cnt SHALL be preserved.

Configuration
REQ-028 Macro CRNGT_ERR_CNT_EN: when defined, crngt_err_cnt SHALL increment by one per curr_test_err pulse, saturate at 8'hFF, and clear only on rst_n or err_clr (err_clr has lower priority than an increment in the same cycle).
REQ-029 When CRNGT_ERR_CNT_EN is undefined, crngt_err_cnt SHALL be tied to 8'h00 with no counter flops.

Verification
REQ-030 Bench SHALL cover: after reset, samples 0x1234, 0x5678 -> no output for 0x1234; crngt_valid with crngt_data=0x5678 one cycle after the second strobe.
REQ-031 Bench SHALL cover: samples 0xAAAA, 0xBBBB, 0xBBBB -> one crngt_valid(0xBBBB), then curr_test_err pulse and crngt_err=1; a following 0xBBBB re-primes with no error.
REQ-032 Bench SHALL cover: accum_enough_bits=1 with samples 0x0001, 0x0002, 0x0002 -> no crngt_valid, one curr_test_err (ref_q still tracked).
REQ-033 Bench SHALL cover: trng_crngt_bypass=1 with 0x5555 repeated 4 times -> no strobes, crngt_err=0.
REQ-034 Bench SHALL cover: rst_trng_logic coincident with collector_valid(0x9999) in ARMED -> no strobe next cycle, FSM in PRIME.
REQ-035 Bench SHALL cover, with CRNGT_ERR_CNT_EN defined: 300 forced failures -> crngt_err_cnt=0xFF; err_clr -> 0x00.
